// File: rtl/uart_rx_frame_fifo_if.sv
// Host-side frame stream: head-of-FIFO entry offered with valid/ready.
// The master drives the frame fields; the slave drives m_ready.
interface uart_rx_frame_fifo_if #(
  parameter int DATA_SIZE = 8
);
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_SIZE-1:0] m_data;
  logic                 m_trans_err;
  logic                 m_data_err;

  modport master (
    output m_valid, m_data, m_trans_err, m_data_err,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_trans_err, m_data_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_frame_fifo.sv
// Buffers completed UART Rx frames in a FWFT FIFO with sticky overflow and a saturating error counter.
// Head is valid one cycle after push into empty; frames arriving while full and not popping are lost (UART_RX_DROP_BAD_FRAME_EN drops errored frames).
module uart_rx_frame_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = $clog2(DEPTH + 1),
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_done,
  input  logic [DATA_SIZE-1:0] rx_data,
  input  logic                 trans_error,
  input  logic                 data_error,
  uart_rx_frame_fifo_if.master m_if,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef UART_RX_DROP_BAD_FRAME_EN
  // Errored frames never enter the FIFO, so only the data byte is stored.
  localparam int EW = DATA_SIZE;
`else
  localparam int EW = DATA_SIZE + 2;
`endif

  logic [EW-1:0]        mem_q [DEPTH];
  logic [EW-1:0]        wr_entry;
  logic [EW-1:0]        head;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 bad_frame, accept, push, pop, ovf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    bad_frame = trans_error | data_error;
`ifdef UART_RX_DROP_BAD_FRAME_EN
    accept   = frame_done & ~bad_frame;
    wr_entry = rx_data;
`else
    accept   = frame_done;
    wr_entry = {trans_error, data_error, rx_data};
`endif
    pop     = ~empty & m_if.m_ready;
    // A full FIFO still takes a frame when the head leaves in the same cycle.
    push    = accept & (~full | pop);
    ovf_set = accept & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    err_cnt_d = err_cnt_q;
    if (frame_done && bad_frame && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    m_if.m_valid = ~empty;
    m_if.m_data  = empty ? '0 : head[DATA_SIZE-1:0];
`ifdef UART_RX_DROP_BAD_FRAME_EN
    m_if.m_trans_err = 1'b0;
    m_if.m_data_err  = 1'b0;
`else
    m_if.m_trans_err = ~empty & head[DATA_SIZE+1];
    m_if.m_data_err  = ~empty & head[DATA_SIZE];
`endif
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_uart_rx_frame_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_done;
  logic [7:0] rx_data;
  logic       trans_error;
  logic       data_error;
  logic       ovf_clr;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] err_cnt;

  uart_rx_frame_fifo_if #(.DATA_SIZE(8)) m_if ();

  uart_rx_frame_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .frame_done  (frame_done),
    .rx_data     (rx_data),
    .trans_error (trans_error),
    .data_error  (data_error),
    .m_if        (m_if),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
`ifdef UART_RX_DROP_BAD_FRAME_EN
  bit drop_mode = 1'b1;
`else
  bit drop_mode = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {trans_err, data_err, data} entries.
  logic [9:0] mq[$];
  bit         m_ovf;
  int         m_err;

  always @(posedge clk) begin
    bit pop_now;
    bit full_now;
    bit bad;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_err = 0;
    end else begin
      bad      = trans_error | data_error;
      pop_now  = (mq.size() > 0) && m_if.m_ready;
      full_now = (mq.size() == DEPTH);
      if (frame_done && bad && m_err < 255) m_err++;
      if (pop_now) void'(mq.pop_front());
      if (frame_done && !(drop_mode && bad)) begin
        if (!full_now || pop_now) mq.push_back({trans_error, data_error, rx_data});
        else m_ovf = 1'b1;
      end else if (ovf_clr) begin
        m_ovf = 1'b0;
      end
      if (frame_done && !(drop_mode && bad) && full_now && !pop_now) m_ovf = 1'b1;
      else if (ovf_clr && !(frame_done && !(drop_mode && bad))) m_ovf = 1'b0;
      else if (ovf_clr) m_ovf = m_ovf && !(full_now == 1'b0 || pop_now) ? 1'b1 : 1'b0;
    end
  end

  always begin
    logic [9:0] hd;
    @(posedge clk);
    #1;
    if (chk_en) begin
      hd = (mq.size() > 0) ? mq[0] : 10'h0;
      chk("m_valid", 32'(m_if.m_valid), 32'(mq.size() > 0));
      chk("m_data", 32'(m_if.m_data), 32'(hd[7:0]));
      chk("m_trans_err", 32'(m_if.m_trans_err), 32'(hd[9]));
      chk("m_data_err", 32'(m_if.m_data_err), 32'(hd[8]));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  // Applies one cycle of inputs, then returns 2 time units after the edge that consumed them.
  task automatic step(input bit r, input bit fd, input logic [7:0] d, input bit te, input bit de,
                      input bit rdy, input bit clr);
    rst         = r;
    frame_done  = fd;
    rx_data     = d;
    trans_error = te;
    data_error  = de;
    m_if.m_ready = rdy;
    ovf_clr     = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic frame(input logic [7:0] d, input bit te, input bit de, input bit rdy);
    step(1'b0, 1'b1, d, te, de, rdy, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("rst_m_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Single frame, then host accepts it.
    frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_valid", 32'(m_if.m_valid), 32'd1);
    chk("a5_data", 32'(m_if.m_data), 32'hA5);
    chk("a5_count", 32'(count), 32'd1);
    idle(1'b1);
    chk("a5_drained", 32'(empty), 32'd1);

    // Fill, overflow, drain in order, clear overflow.
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    frame(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(m_if.m_data), 32'(i));
      idle(1'b1);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
    frame(8'h55, 1'b0, 1'b0, 1'b1);
    chk("fullpp_count", 32'(count), 32'd8);
    chk("fullpp_ovf", 32'(overflow), 32'd0);
    chk("fullpp_head", 32'(m_if.m_data), 32'h01);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("fullpp_last", 32'(m_if.m_data), 32'h55);
    idle(1'b1);
    chk("fullpp_empty", 32'(empty), 32'd1);

    // Errored frame.
    frame(8'h3C, 1'b1, 1'b1, 1'b0);
    chk("bad_err_cnt", 32'(err_cnt), 32'd1);
    if (drop_mode) begin
      chk("bad_dropped", 32'(empty), 32'd1);
    end else begin
      chk("bad_data", 32'(m_if.m_data), 32'h3C);
      chk("bad_terr", 32'(m_if.m_trans_err), 32'd1);
      chk("bad_derr", 32'(m_if.m_data_err), 32'd1);
    end
    idle(1'b1);

    // Error counter saturation with host draining.
    for (int i = 0; i < 300; i++) frame(8'(i), 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    chk("err_sat", 32'(err_cnt), 32'd255);

    // Overflow set wins over a same-cycle clear.
    for (int i = 0; i < 8; i++) frame(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("three_left", 32'(count), 32'd3);

    // Reset with entries buffered.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_mid_err", 32'(err_cnt), 32'd0);
    chk("rst_mid_ovf", 32'(overflow), 32'd0);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
